// File: rtl/jelly2_cache_tag_arbiter_if.sv
// Requester-side bundle for the cache tag arbiter: N lookup channels in, N result channels out.
// Latency: none, wires only.
// Backpressure: s_valid/s_ready per lookup port, m_valid/m_ready per result port.
interface jelly2_cache_tag_arbiter_if #(
    parameter int N           = 4,
    parameter int USER_WIDTH  = 0,
    parameter int INDEX_WIDTH = 12,
    parameter int TAG_WIDTH   = 6
);
    localparam int USER_BITS = USER_WIDTH > 0 ? USER_WIDTH : 1;

    logic [N-1:0][USER_BITS-1:0]   s_user;
    logic [N-1:0][INDEX_WIDTH-1:0] s_index;
    logic [N-1:0][TAG_WIDTH-1:0]   s_tag;
    logic [N-1:0]                  s_strb;
    logic [N-1:0]                  s_valid;
    logic [N-1:0]                  s_ready;

    logic [N-1:0][USER_BITS-1:0]   m_user;
    logic [N-1:0][INDEX_WIDTH-1:0] m_index;
    logic [N-1:0][TAG_WIDTH-1:0]   m_tag;
    logic [N-1:0]                  m_hit;
    logic [N-1:0]                  m_strb;
    logic [N-1:0]                  m_valid;
    logic [N-1:0]                  m_ready;

    // requester side
    modport master (
        output s_user, s_index, s_tag, s_strb, s_valid,
        input  s_ready,
        input  m_user, m_index, m_tag, m_hit, m_strb, m_valid,
        output m_ready
    );

    // arbiter side
    modport slave (
        input  s_user, s_index, s_tag, s_strb, s_valid,
        output s_ready,
        output m_user, m_index, m_tag, m_hit, m_strb, m_valid,
        input  m_ready
    );
endinterface

// File: rtl/jelly2_cache_tag_arbiter.sv
// Round-robin share of one direct-mapped tag unit among N ports, plus clear sequencing.
// Latency: 3 tag_cke cycles from s_valid&s_ready to m_valid (the tag unit's own pipeline).
// Backpressure: a result not accepted freezes the tag pipeline via tag_cke. Option: CACHE_TAG_ARB_STAT_EN.
module jelly2_cache_tag_arbiter #(
    parameter  int N             = 4,
    parameter  int USER_WIDTH    = 0,
    parameter  int INDEX_WIDTH   = 12,
    parameter  int TAG_WIDTH     = 6,
    parameter  int STAT_WIDTH    = 32,
    localparam int ID_BITS       = N > 1 ? $clog2(N) : 1,
    localparam int USER_BITS     = USER_WIDTH > 0 ? USER_WIDTH : 1,
    localparam int TAG_USER_BITS = ID_BITS + USER_BITS
) (
    input  logic                     reset,
    input  logic                     clk,
    input  logic                     cke,

    input  logic                     clear_req,
    output logic                     clear_busy,

    jelly2_cache_tag_arbiter_if.slave s,

    output logic                     tag_cke,
    output logic                     tag_clear_start,
    input  logic                     tag_clear_busy,

    output logic [TAG_USER_BITS-1:0] tag_s_user,
    output logic [INDEX_WIDTH-1:0]   tag_s_index,
    output logic [TAG_WIDTH-1:0]     tag_s_tag,
    output logic                     tag_s_strb,
    output logic                     tag_s_valid,

    input  logic [TAG_USER_BITS-1:0] tag_m_user,
    input  logic [INDEX_WIDTH-1:0]   tag_m_index,
    input  logic [TAG_WIDTH-1:0]     tag_m_tag,
    input  logic                     tag_m_hit,
    input  logic                     tag_m_strb,
    input  logic                     tag_m_valid
`ifdef CACHE_TAG_ARB_STAT_EN
    ,
    output logic [STAT_WIDTH-1:0]    stat_access,
    output logic [STAT_WIDTH-1:0]    stat_hit
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRAIN,
        ST_START,
        ST_WAIT
    } state_t;

    localparam logic [ID_BITS:0] N_EXT = (ID_BITS+1)'(N);

    state_t             state;
    logic               busy_seen;
    logic [ID_BITS-1:0] rr_ptr;
    logic [1:0]         inflight;

    logic [ID_BITS-1:0] grant_id;
    logic               grant_any;
    logic [ID_BITS:0]   cand;
    logic               grant_vld;
    logic [ID_BITS-1:0] res_id;
    logic               stall;
    logic               xfer;
    logic               start_entry;

    // The result's owner is carried in the upper bits of the tag unit user field.
    assign res_id  = tag_m_user[TAG_USER_BITS-1 -: ID_BITS];
    assign stall   = tag_m_valid & ~s.m_ready[res_id];
    assign tag_cke = cke & ~stall;
    assign xfer    = tag_cke & tag_m_valid;

    // Pick the first requesting port at or after rr_ptr; the lowest offset wins.
    always_comb begin
        grant_any = 1'b0;
        grant_id  = '0;
        cand      = '0;
        for (int k = N - 1; k >= 0; k--) begin
            cand = {1'b0, rr_ptr} + (ID_BITS+1)'(k);
            if (cand >= N_EXT) begin
                cand = cand - N_EXT;
            end
            if (s.s_valid[cand[ID_BITS-1:0]]) begin
                grant_any = 1'b1;
                grant_id  = cand[ID_BITS-1:0];
            end
        end
    end

    // A grant is a handshake: it only exists when the pipeline advances this cycle.
    assign grant_vld   = grant_any & (state == ST_IDLE) & tag_cke & ~reset;
    assign tag_s_valid = grant_vld;
    assign tag_s_user  = {grant_id, s.s_user[grant_id]};
    assign tag_s_index = s.s_index[grant_id];
    assign tag_s_tag   = s.s_tag[grant_id];
    assign tag_s_strb  = s.s_strb[grant_id];

    assign start_entry = cke & (state == ST_DRAIN) & (inflight == 2'd0);

    for (genvar i = 0; i < N; i++) begin : g_port
        assign s.s_ready[i] = grant_vld & (grant_id == ID_BITS'(i));
        assign s.m_valid[i] = tag_m_valid & (res_id == ID_BITS'(i));
        assign s.m_user[i]  = tag_m_user[USER_BITS-1:0];
        assign s.m_index[i] = tag_m_index;
        assign s.m_tag[i]   = tag_m_tag;
        assign s.m_hit[i]   = tag_m_hit;
        assign s.m_strb[i]  = tag_m_strb;
    end

    // Round-robin pointer moves just past the port that was served.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr <= '0;
        end else if (grant_vld) begin
            if (grant_id == ID_BITS'(N - 1)) begin
                rr_ptr <= '0;
            end else begin
                rr_ptr <= grant_id + 1'b1;
            end
        end
    end

    // Lookups issued but whose result has not yet been handed over.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            inflight <= 2'd0;
        end else begin
            case ({grant_vld, xfer})
                2'b10:   inflight <= inflight + 2'd1;
                2'b01:   inflight <= inflight - 2'd1;
                default: inflight <= inflight;
            endcase
        end
    end

    // Clear sequencer: stop grants, drain, pulse the tag unit, wait for its busy to fall.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= ST_IDLE;
            clear_busy      <= 1'b0;
            tag_clear_start <= 1'b0;
            busy_seen       <= 1'b0;
        end else if (cke) begin
            case (state)
                ST_IDLE: begin
                    if (clear_req) begin
                        state      <= ST_DRAIN;
                        clear_busy <= 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (inflight == 2'd0) begin
                        state           <= ST_START;
                        tag_clear_start <= 1'b1;
                        busy_seen       <= 1'b0;
                    end
                end
                ST_START: begin
                    busy_seen <= 1'b0;
                    if (tag_cke) begin
                        state           <= ST_WAIT;
                        tag_clear_start <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (tag_clear_busy) begin
                        busy_seen <= 1'b1;
                    end else if (busy_seen) begin
                        state      <= ST_IDLE;
                        clear_busy <= 1'b0;
                    end
                end
                default: begin
                    state           <= ST_IDLE;
                    clear_busy      <= 1'b0;
                    tag_clear_start <= 1'b0;
                end
            endcase
        end
    end

`ifdef CACHE_TAG_ARB_STAT_EN
    // Count delivered results and hits among them; restart when a clear begins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_access <= '0;
            stat_hit    <= '0;
        end else if (start_entry) begin
            stat_access <= '0;
            stat_hit    <= '0;
        end else if (xfer) begin
            stat_access <= stat_access + 1'b1;
            if (tag_m_hit) begin
                stat_hit <= stat_hit + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_jelly2_cache_tag_arbiter.sv
// Bench for jelly2_cache_tag_arbiter with a behavioural 3-stage direct-mapped tag unit.
// Expected results come from stimulus records and go to per-port scoreboard queues.
// Results are popped and compared when the arbiter hands them over.
module tb_jelly2_cache_tag_arbiter;
    localparam int N   = 4;
    localparam int UW  = 4;
    localparam int IW  = 12;
    localparam int TW  = 6;
    localparam int IDB = 2;
    localparam int TUW = IDB + UW;

    logic clk, reset, cke, clear_req, clear_busy;
    logic tag_cke, tag_clear_start, tag_clear_busy;
    logic [TUW-1:0] tag_s_user, tag_m_user;
    logic [IW-1:0]  tag_s_index, tag_m_index;
    logic [TW-1:0]  tag_s_tag, tag_m_tag;
    logic tag_s_strb, tag_s_valid, tag_m_hit, tag_m_strb, tag_m_valid;
`ifdef CACHE_TAG_ARB_STAT_EN
    logic [31:0] stat_access, stat_hit;
`endif

    jelly2_cache_tag_arbiter_if #(.N(N), .USER_WIDTH(UW), .INDEX_WIDTH(IW), .TAG_WIDTH(TW)) bus ();

    jelly2_cache_tag_arbiter #(.N(N), .USER_WIDTH(UW), .INDEX_WIDTH(IW), .TAG_WIDTH(TW), .STAT_WIDTH(32)) dut (
        .reset(reset), .clk(clk), .cke(cke),
        .clear_req(clear_req), .clear_busy(clear_busy),
        .s(bus),
        .tag_cke(tag_cke), .tag_clear_start(tag_clear_start), .tag_clear_busy(tag_clear_busy),
        .tag_s_user(tag_s_user), .tag_s_index(tag_s_index), .tag_s_tag(tag_s_tag),
        .tag_s_strb(tag_s_strb), .tag_s_valid(tag_s_valid),
        .tag_m_user(tag_m_user), .tag_m_index(tag_m_index), .tag_m_tag(tag_m_tag),
        .tag_m_hit(tag_m_hit), .tag_m_strb(tag_m_strb), .tag_m_valid(tag_m_valid)
`ifdef CACHE_TAG_ARB_STAT_EN
        , .stat_access(stat_access), .stat_hit(stat_hit)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- behavioural tag unit ----------------
    logic [(1<<IW)-1:0] mv;
    logic [TW-1:0]      mt [1<<IW];
    logic [3:1]         p_vld;
    logic [TUW-1:0]     p_user  [1:3];
    logic [IW-1:0]      p_index [1:3];
    logic [TW-1:0]      p_tag   [1:3];
    logic [3:1]         p_hit, p_strb;
    int                 busy_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            p_vld    <= '0;
            busy_cnt <= 0;
            mv       <= '0;
        end else if (tag_cke) begin
            p_vld[1]   <= tag_s_valid;
            p_user[1]  <= tag_s_user;
            p_index[1] <= tag_s_index;
            p_tag[1]   <= tag_s_tag;
            p_strb[1]  <= tag_s_strb;
            p_hit[1]   <= mv[tag_s_index] && (mt[tag_s_index] == tag_s_tag);
            for (int k = 2; k <= 3; k++) begin
                p_vld[k]   <= p_vld[k-1];
                p_user[k]  <= p_user[k-1];
                p_index[k] <= p_index[k-1];
                p_tag[k]   <= p_tag[k-1];
                p_strb[k]  <= p_strb[k-1];
                p_hit[k]   <= p_hit[k-1];
            end
            if (tag_s_valid && tag_s_strb) begin
                mv[tag_s_index] <= 1'b1;
                mt[tag_s_index] <= tag_s_tag;
            end
            if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
            if (tag_clear_start) begin
                busy_cnt <= 1 << TW;
                mv       <= '0;
            end
        end
    end

    assign tag_m_valid    = p_vld[3];
    assign tag_m_user     = p_user[3];
    assign tag_m_index    = p_index[3];
    assign tag_m_tag      = p_tag[3];
    assign tag_m_hit      = p_hit[3];
    assign tag_m_strb     = p_strb[3];
    assign tag_clear_busy = (busy_cnt != 0);

    // ---------------- checking ----------------
    typedef struct packed {
        logic [UW-1:0] user;
        logic [IW-1:0] index;
        logic [TW-1:0] tag;
        logic          hit;
        logic          strb;
    } exp_t;

    typedef struct {
        int            p;
        logic [IW-1:0] idx;
        logic [TW-1:0] tg;
        logic          st;
        logic [UW-1:0] usr;
        logic          h;
    } vec_t;

    exp_t       sb [N][$];
    logic [1:0] glog [$];
    int         gcyc [$];
    logic [1:0] rlog [$];
    int         cyc;
    int         busy_grant;
    int         passed, total;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic int sb_total();
        int t = 0;
        for (int i = 0; i < N; i++) t += sb[i].size();
        return t;
    endfunction

    task automatic monitor();
        forever begin
            @(negedge clk);
            #1;
            cyc++;
            if (!reset && cke) begin
                if (tag_s_valid && clear_busy) busy_grant++;
                if (tag_s_valid) begin
                    glog.push_back(tag_s_user[TUW-1 -: IDB]);
                    gcyc.push_back(cyc);
                end
                for (int i = 0; i < N; i++) begin
                    if (bus.m_valid[i] && bus.m_ready[i]) begin
                        rlog.push_back(2'(i));
                        if (sb[i].size() == 0) begin
                            check("unexpected_result", 64'(i), 64'hff);
                        end else begin
                            exp_t e = sb[i].pop_front();
                            exp_t a = '{bus.m_user[i], bus.m_index[i], bus.m_tag[i], bus.m_hit[i], bus.m_strb[i]};
                            check($sformatf("result_port%0d", i), 64'(a), 64'(e));
                        end
                    end
                end
            end
        end
    endtask

    task automatic lookup(input int p, input logic [IW-1:0] idx, input logic [TW-1:0] tg,
                          input logic st, input logic [UW-1:0] usr, input logic h);
        bit ok = 0;
        sb[p].push_back('{usr, idx, tg, h, st});
        @(negedge clk);
        bus.s_index[p] = idx;
        bus.s_tag[p]   = tg;
        bus.s_strb[p]  = st;
        bus.s_user[p]  = usr;
        bus.s_valid[p] = 1'b1;
        for (int c = 0; c < 300; c++) begin
            #1;
            if (bus.s_ready[p]) begin
                ok = 1;
                @(negedge clk);
                break;
            end
            @(negedge clk);
        end
        bus.s_valid[p] = 1'b0;
        if (!ok) check("accept_timeout", 64'(p), 64'hff);
    endtask

    task automatic port_burst(input int p, input int base, input int n);
        for (int j = 0; j < n; j++) lookup(p, IW'(base + j), TW'(p), 1'b0, UW'(j), 1'b0);
    endtask

    task automatic wait_idle(input string name);
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            #1;
            if (sb_total() == 0 && !tag_m_valid) break;
        end
        check(name, 64'(sb_total()), 64'd0);
    endtask

    task automatic do_clear();
        @(negedge clk);
        clear_req = 1'b1;
        @(negedge clk);
        clear_req = 1'b0;
        for (int c = 0; c < 200; c++) begin
            #1;
            if (!clear_busy) break;
            @(negedge clk);
        end
        check("clear_done", 64'(clear_busy), 64'd0);
    endtask

    function automatic logic [7:0] order4(input logic [1:0] q [$]);
        if (q.size() != 4) return 8'hff;
        return {q[0], q[1], q[2], q[3]};
    endfunction

    vec_t vt [12];
    int   lat, bad, busy_cyc, start_cyc, drain_bad;
    logic [N-1:0] rdy;

    initial begin
        passed = 0; total = 0; cyc = 0; busy_grant = 0;
        reset = 1'b1; cke = 1'b1; clear_req = 1'b0;
        bus.s_user = '0; bus.s_index = '0; bus.s_tag = '0; bus.s_strb = '0;
        bus.s_valid = '1; bus.m_ready = '1;

        vt[0]  = '{0, 12'd5,    6'd3,  1'b1, 4'd1,  1'b0};
        vt[1]  = '{0, 12'd5,    6'd3,  1'b1, 4'd2,  1'b1};
        vt[2]  = '{1, 12'd5,    6'd3,  1'b0, 4'd3,  1'b1};
        vt[3]  = '{2, 12'd5,    6'd4,  1'b0, 4'd4,  1'b0};
        vt[4]  = '{3, 12'd5,    6'd4,  1'b1, 4'd5,  1'b0};
        vt[5]  = '{0, 12'd5,    6'd3,  1'b0, 4'd6,  1'b0};
        vt[6]  = '{1, 12'd4095, 6'd63, 1'b1, 4'd7,  1'b0};
        vt[7]  = '{1, 12'd4095, 6'd63, 1'b0, 4'd8,  1'b1};
        vt[8]  = '{2, 12'd0,    6'd0,  1'b1, 4'd9,  1'b0};
        vt[9]  = '{3, 12'd0,    6'd0,  1'b0, 4'd10, 1'b1};
        vt[10] = '{0, 12'd5,    6'd3,  1'b1, 4'd11, 1'b0};
        vt[11] = '{3, 12'd5,    6'd3,  1'b0, 4'd12, 1'b1};

        fork monitor(); join_none

        // reset state, with every port requesting
        repeat (3) @(negedge clk);
        #1;
        check("rst_s_ready", 64'(bus.s_ready), 64'd0);
        check("rst_tag_s_valid", 64'(tag_s_valid), 64'd0);
        check("rst_clear_busy", 64'(clear_busy), 64'd0);
        check("rst_tag_clear_start", 64'(tag_clear_start), 64'd0);
        check("rst_m_valid", 64'(bus.m_valid), 64'd0);
        @(negedge clk);
        bus.s_valid = '0;
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // lookup latency
        sb[0].push_back('{4'd9, 12'd100, 6'd7, 1'b0, 1'b1});
        bus.s_index[0] = 12'd100; bus.s_tag[0] = 6'd7; bus.s_strb[0] = 1'b1; bus.s_user[0] = 4'd9;
        bus.s_valid[0] = 1'b1;
        #1;
        check("lat_s_ready", 64'(bus.s_ready[0]), 64'd1);
        @(negedge clk);
        bus.s_valid[0] = 1'b0;
        lat = 1;
        for (int c = 0; c < 10; c++) begin
            #1;
            if (bus.m_valid[0]) break;
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        check("lookup_latency", 64'(lat), 64'd3);
        wait_idle("drain_latency");

        // sequential vectors: hit/miss/allocate, boundary index and tag values
        for (int v = 0; v < 12; v++) lookup(vt[v].p, vt[v].idx, vt[v].tg, vt[v].st, vt[v].usr, vt[v].h);
        wait_idle("drain_table");

        // four ports at once from rr_ptr=0
        glog.delete(); gcyc.delete(); rlog.delete();
        fork
            lookup(0, 12'd200, 6'd10, 1'b1, 4'd0, 1'b0);
            lookup(1, 12'd201, 6'd11, 1'b1, 4'd1, 1'b0);
            lookup(2, 12'd202, 6'd12, 1'b1, 4'd2, 1'b0);
            lookup(3, 12'd203, 6'd13, 1'b1, 4'd3, 1'b0);
        join
        wait_idle("drain_rr");
        check("rr_grant_order", 64'(order4(glog)), 64'h1b);
        check("rr_consecutive", (gcyc.size() == 4) ? 64'(gcyc[3] - gcyc[0]) : 64'hff, 64'd3);
        check("rr_result_order", 64'(order4(rlog)), 64'h1b);

        // back-pressure on port 2 freezes the pipeline
        @(negedge clk);
        bus.m_ready[2] = 1'b0;
        rlog.delete();
        fork
            lookup(0, 12'd300, 6'd1, 1'b1, 4'd4, 1'b0);
            lookup(1, 12'd301, 6'd2, 1'b1, 4'd5, 1'b0);
            lookup(2, 12'd302, 6'd3, 1'b1, 4'd6, 1'b0);
            lookup(3, 12'd303, 6'd4, 1'b1, 4'd7, 1'b0);
        join
        for (int c = 0; c < 30; c++) begin
            if (bus.m_valid[2]) break;
            @(negedge clk);
            #1;
        end
        check("stall_result_valid", 64'(bus.m_valid[2]), 64'd1);
        bad = 0;
        for (int k = 0; k < 5; k++) begin
            if (tag_cke !== 1'b0 || bus.m_valid !== 4'b0100) bad++;
            @(negedge clk);
            if (k != 4) #1;
        end
        bus.m_ready[2] = 1'b1;
        check("stall_frozen_cycles_bad", 64'(bad), 64'd0);
        wait_idle("drain_stall");
        check("stall_result_order", 64'(order4(rlog)), 64'h1b);

        // cke low freezes everything, including a clear request
        lookup(1, 12'd400, 6'd9, 1'b1, 4'd8, 1'b0);
        cke = 1'b0;
        clear_req = 1'b1;
        bad = 0;
        for (int k = 0; k < 4; k++) begin
            #1;
            if (tag_cke !== 1'b0 || clear_busy !== 1'b0) bad++;
            @(negedge clk);
        end
        clear_req = 1'b0;
        cke = 1'b1;
        check("cke_freeze_bad", 64'(bad), 64'd0);
        wait_idle("drain_cke");

        // clear in the middle of four-port traffic
        busy_grant = 0; busy_cyc = 0; start_cyc = 0; drain_bad = 0;
        fork
            port_burst(0, 500, 3);
            port_burst(1, 510, 3);
            port_burst(2, 520, 3);
            port_burst(3, 530, 3);
            begin
                repeat (3) @(negedge clk);
                clear_req = 1'b1;
                @(negedge clk);
                clear_req = 1'b0;
                for (int c = 0; c < 200; c++) begin
                    #1;
                    if (clear_busy) busy_cyc++;
                    if (tag_clear_start) begin
                        start_cyc++;
                        if (tag_m_valid) drain_bad++;
                    end
                    if (!clear_busy) break;
                    @(negedge clk);
                end
            end
        join
        wait_idle("drain_clear");
        check("clear_start_cycles", 64'(start_cyc), 64'd1);
        check("clear_drained", 64'(drain_bad), 64'd0);
        check("clear_no_grants", 64'(busy_grant), 64'd0);
        check("clear_busy_len_ok", 64'(busy_cyc >= 64 && busy_cyc <= 80), 64'd1);
        lookup(0, 12'd5, 6'd3, 1'b0, 4'd13, 1'b0);
        wait_idle("drain_after_clear");

        // reset in the middle of WAIT
        lookup(1, 12'd600, 6'd5, 1'b0, 4'd14, 1'b0);
        wait_idle("drain_pre_reset");
        @(negedge clk);
        clear_req = 1'b1;
        @(negedge clk);
        clear_req = 1'b0;
        for (int c = 0; c < 50; c++) begin
            #1;
            if (tag_clear_busy) break;
            @(negedge clk);
        end
        check("wait_entered", 64'(tag_clear_busy), 64'd1);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < N; i++) begin
            bus.s_index[i] = IW'(700 + i); bus.s_tag[i] = TW'(i); bus.s_strb[i] = 1'b0;
            bus.s_user[i] = UW'(i);
        end
        bus.s_valid = '1;
        #1;
        check("rst_wait_clear_busy", 64'(clear_busy), 64'd0);
        check("rst_wait_s_ready", 64'(bus.s_ready), 64'd0);
        check("rst_wait_clear_start", 64'(tag_clear_start), 64'd0);
        for (int i = 0; i < N; i++) sb[i].push_back('{UW'(i), IW'(700 + i), TW'(i), 1'b0, 1'b0});
        glog.delete(); gcyc.delete();
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 20; c++) begin
            #1;
            rdy = bus.s_ready;
            @(negedge clk);
            bus.s_valid = bus.s_valid & ~rdy;
            if (bus.s_valid == '0) break;
        end
        bus.s_valid = '0;
        wait_idle("drain_post_reset");
        check("post_reset_order", 64'(order4(glog)), 64'h1b);

`ifdef CACHE_TAG_ARB_STAT_EN
        do_clear();
        check("stat_access_cleared", 64'(stat_access), 64'd0);
        check("stat_hit_cleared", 64'(stat_hit), 64'd0);
        for (int i = 0; i < 4; i++) lookup(i, IW'(800 + i), 6'd1, 1'b1, 4'd0, 1'b0);
        for (int i = 0; i < 6; i++) lookup(i % 4, IW'(800 + (i % 4)), 6'd1, 1'b0, 4'd1, 1'b1);
        wait_idle("drain_stat");
        check("stat_access", 64'(stat_access), 64'd10);
        check("stat_hit", 64'(stat_hit), 64'd6);
        do_clear();
        check("stat_access_after_clear", 64'(stat_access), 64'd0);
        check("stat_hit_after_clear", 64'(stat_hit), 64'd0);
`endif

        check("scoreboard_empty", 64'(sb_total()), 64'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end
endmodule
